// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Purpose  : RV32I instruction-decode stage. Holds the fetched instruction
//            in an IF/ID latch, decodes register indices, funct3, inst[30]
//            and the sign-extended immediate, and reads a 32x32 register
//            file with write-back bypass. Detects load-use hazards and
//            presents a bubble towards ID/EX while the latch holds.
// Ports    : clk_in/rst_in      clock, synchronous active-high reset
//            rdy_in             global enable (freezes latch and regfile)
//            clear/stall        flush to NOP / hold latch
//            if_valid/pc/inst   fetched instruction
//            wb_enable/addr/data register write-back
//            ex_ins_type/rd_addr instruction currently at ID/EX output
//            pc..ins_diff       decoded fields (bubble when idle/hazard)
//            load_use_stall     hazard request to fetch/PC logic
// Revision : 1.0 - initial release
// ============================================================================
module id_stage #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            clear,
    input  logic            stall,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_inst,
    input  logic            wb_enable,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic [6:0]      ex_ins_type,
    input  logic [4:0]      ex_rd_addr,
    output logic [XLEN-1:0] pc,
    output logic [4:0]      r1_addr,
    output logic [XLEN-1:0] r1_data,
    output logic [4:0]      r2_addr,
    output logic [XLEN-1:0] r2_data,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] imm,
    output logic [6:0]      ins_type,
    output logic [2:0]      ins_details,
    output logic            ins_diff,
    output logic            load_use_stall
);

    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_regs [32];

    logic [6:0]      w_opc;
    logic            w_has_rs1;
    logic            w_has_rs2;
    logic            w_has_rd;
    logic            w_has_f3;
    logic [XLEN-1:0] w_imm;
    logic [4:0]      w_rs1_idx;
    logic [4:0]      w_rs2_idx;
    logic [4:0]      w_rd_idx;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic            w_diff;
    logic            w_lus;
    logic            w_bubble;

    // IF/ID latch
    always_ff @(posedge clk_in) begin
        if (rst_in || clear) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_inst  <= NOP_INST;
        end else if (rdy_in && !(stall || w_lus)) begin
            r_valid <= if_valid;
            r_pc    <= if_pc;
            r_inst  <= if_valid ? if_inst : NOP_INST;
        end
    end

    // Register file; x0 is never written so it stays zero after reset
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (rdy_in && wb_enable && (wb_addr != 5'd0)) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    assign w_opc = r_inst[6:0];

    // Format classification; anything not listed decodes as I-type
    always_comb begin
        w_has_rs1 = 1'b1;
        w_has_rs2 = 1'b0;
        w_has_rd  = 1'b1;
        w_has_f3  = 1'b1;
        w_imm     = {{(XLEN-12){r_inst[31]}}, r_inst[31:20]};
        case (w_opc)
            c_OPC_LUI, c_OPC_AUIPC: begin
                w_has_rs1 = 1'b0;
                w_has_f3  = 1'b0;
                w_imm     = {r_inst[31:12], 12'b0};
            end
            c_OPC_JAL: begin
                w_has_rs1 = 1'b0;
                w_has_f3  = 1'b0;
                w_imm     = {{(XLEN-20){r_inst[31]}}, r_inst[19:12], r_inst[20],
                             r_inst[30:21], 1'b0};
            end
            c_OPC_BRANCH: begin
                w_has_rs2 = 1'b1;
                w_has_rd  = 1'b0;
                w_imm     = {{(XLEN-12){r_inst[31]}}, r_inst[7], r_inst[30:25],
                             r_inst[11:8], 1'b0};
            end
            c_OPC_STORE: begin
                w_has_rs2 = 1'b1;
                w_has_rd  = 1'b0;
                w_imm     = {{(XLEN-12){r_inst[31]}}, r_inst[31:25], r_inst[11:7]};
            end
            c_OPC_OP: begin
                w_has_rs2 = 1'b1;
                w_imm     = '0;
            end
            default: begin
            end
        endcase
    end

    assign w_rs1_idx = w_has_rs1 ? r_inst[19:15] : 5'd0;
    assign w_rs2_idx = w_has_rs2 ? r_inst[24:20] : 5'd0;
    assign w_rd_idx  = w_has_rd  ? r_inst[11:7]  : 5'd0;

    // inst[30] only distinguishes SUB/SRA and SRAI from their siblings
    assign w_diff = ((w_opc == c_OPC_OP) ||
                     ((w_opc == c_OPC_OPIMM) && (r_inst[14:12] == 3'b101))) ? r_inst[30] : 1'b0;

    // Read with bypass so a same-cycle write-back is seen immediately
    assign w_rs1_val = (w_rs1_idx == 5'd0) ? '0 :
                       (wb_enable && (wb_addr == w_rs1_idx)) ? wb_data : r_regs[w_rs1_idx];
    assign w_rs2_val = (w_rs2_idx == 5'd0) ? '0 :
                       (wb_enable && (wb_addr == w_rs2_idx)) ? wb_data : r_regs[w_rs2_idx];

    // Hazard compares against format-qualified indices, so unused fields never match
    assign w_lus = r_valid && (ex_ins_type == c_OPC_LOAD) && (ex_rd_addr != 5'd0) &&
                   ((ex_rd_addr == w_rs1_idx) || (ex_rd_addr == w_rs2_idx));

    assign w_bubble = !r_valid || w_lus;

    assign pc             = r_pc;
    assign r1_addr        = w_bubble ? 5'd0 : w_rs1_idx;
    assign r1_data        = w_bubble ? '0 : w_rs1_val;
    assign r2_addr        = w_bubble ? 5'd0 : w_rs2_idx;
    assign r2_data        = w_bubble ? '0 : w_rs2_val;
    assign rd_addr        = w_bubble ? 5'd0 : w_rd_idx;
    assign imm            = w_bubble ? '0 : w_imm;
    assign ins_type       = w_bubble ? c_OPC_OPIMM : w_opc;
    assign ins_details    = (w_bubble || !w_has_f3) ? 3'd0 : r_inst[14:12];
    assign ins_diff       = w_bubble ? 1'b0 : w_diff;
    assign load_use_stall = w_lus;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage
// Purpose  : Self-checking bench for id_stage. Directed scenarios followed by
//            randomized traffic, all compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst, rdy, clr, stl, if_valid, wb_enable;
    logic [31:0] if_pc, if_inst, wb_data;
    logic [4:0]  wb_addr, ex_rd_addr;
    logic [6:0]  ex_ins_type;
    logic [31:0] pc, r1_data, r2_data, imm;
    logic [4:0]  r1_addr, r2_addr, rd_addr;
    logic [6:0]  ins_type;
    logic [2:0]  ins_details;
    logic        ins_diff, load_use_stall;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_stage dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear(clr), .stall(stl),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .wb_enable(wb_enable), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_ins_type(ex_ins_type), .ex_rd_addr(ex_rd_addr),
        .pc(pc), .r1_addr(r1_addr), .r1_data(r1_data), .r2_addr(r2_addr),
        .r2_data(r2_data), .rd_addr(rd_addr), .imm(imm), .ins_type(ins_type),
        .ins_details(ins_details), .ins_diff(ins_diff),
        .load_use_stall(load_use_stall)
    );

    // ---------------- behavioural model ----------------
    logic        m_valid;
    logic [31:0] m_pc, m_inst;
    logic [31:0] m_rf [32];

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [6:0]  typ;
        logic [2:0]  f3;
        logic        diff;
    } dec_t;

    function automatic int sext(input int v, input int bits);
        if (v >= (1 << (bits - 1))) return v - (1 << bits);
        return v;
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t d;
        byte  fmt;
        int   v;
        case (w[6:0])
            7'h37, 7'h17: fmt = "U";
            7'h6F:        fmt = "J";
            7'h63:        fmt = "B";
            7'h23:        fmt = "S";
            7'h33:        fmt = "R";
            default:      fmt = "I";
        endcase
        d.typ = w[6:0];
        d.rs1 = (fmt == "U" || fmt == "J") ? 5'd0 : w[19:15];
        d.rs2 = (fmt == "R" || fmt == "S" || fmt == "B") ? w[24:20] : 5'd0;
        d.rd  = (fmt == "S" || fmt == "B") ? 5'd0 : w[11:7];
        d.f3  = (fmt == "U" || fmt == "J") ? 3'd0 : w[14:12];
        case (fmt)
            "I": v = sext(int'(w[31:20]), 12);
            "S": v = sext(int'(w[31:25]) * 32 + int'(w[11:7]), 12);
            "B": v = sext(int'(w[31]) * 4096 + int'(w[7]) * 2048 +
                          int'(w[30:25]) * 32 + int'(w[11:8]) * 2, 13);
            "J": v = sext(int'(w[31]) * (1 << 20) + int'(w[19:12]) * 4096 +
                          int'(w[20]) * 2048 + int'(w[30:21]) * 2, 21);
            "U": v = int'(w & 32'hFFFF_F000);
            default: v = 0;
        endcase
        d.imm  = 32'(v);
        d.diff = (w[6:0] == 7'h33 || (w[6:0] == 7'h13 && w[14:12] == 3'd5)) ? w[30] : 1'b0;
        return d;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_enable && wb_addr == a) return wb_data;
        return m_rf[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called mid-cycle with inputs settled: check outputs, clock once, update model
    task automatic step();
        dec_t        d;
        logic        lus, bub;
        d   = ref_decode(m_inst);
        lus = m_valid && ex_ins_type == 7'b0000011 && ex_rd_addr != 5'd0 &&
              (ex_rd_addr == d.rs1 || ex_rd_addr == d.rs2);
        bub = !m_valid || lus;
        chk("pc",       pc,             m_pc);
        chk("lus",      32'(load_use_stall), 32'(lus));
        chk("ins_type", 32'(ins_type),  bub ? 32'h13 : 32'(d.typ));
        chk("details",  32'(ins_details), bub ? 32'd0 : 32'(d.f3));
        chk("diff",     32'(ins_diff),  bub ? 32'd0 : 32'(d.diff));
        chk("rd_addr",  32'(rd_addr),   bub ? 32'd0 : 32'(d.rd));
        chk("imm",      imm,            bub ? 32'd0 : d.imm);
        chk("r1_addr",  32'(r1_addr),   bub ? 32'd0 : 32'(d.rs1));
        chk("r2_addr",  32'(r2_addr),   bub ? 32'd0 : 32'(d.rs2));
        chk("r1_data",  r1_data,        bub ? 32'd0 : ref_read(d.rs1));
        chk("r2_data",  r2_data,        bub ? 32'd0 : ref_read(d.rs2));
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        end else if (rdy && wb_enable && wb_addr != 5'd0) begin
            m_rf[wb_addr] = wb_data;
        end
        if (rst || clr) begin
            m_valid = 1'b0; m_pc = 32'd0; m_inst = 32'h13;
        end else if (rdy && !(stl || lus)) begin
            m_valid = if_valid; m_pc = if_pc; m_inst = if_valid ? if_inst : 32'h13;
        end
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] p, input logic [31:0] w);
        if_valid = 1'b1; if_pc = p; if_inst = w;
    endtask

    logic [6:0]  opcs [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    logic [31:0] rnd;

    initial begin
        rst = 1'b1; rdy = 1'b1; clr = 1'b0; stl = 1'b0; if_valid = 1'b0;
        if_pc = '0; if_inst = '0; wb_enable = 1'b0; wb_addr = '0; wb_data = '0;
        ex_ins_type = '0; ex_rd_addr = '0;
        @(posedge clk); @(posedge clk);
        m_valid = 1'b0; m_pc = '0; m_inst = 32'h13;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        @(negedge clk);
        rst = 1'b0;

        // Reset state and first decode: addi x1,x0,5
        fetch(32'h100, 32'h0050_0093); #1;
        chk("rst_type", 32'(ins_type), 32'h13);
        chk("rst_pc", pc, 32'd0);
        chk("rst_lus", 32'(load_use_stall), 32'd0);
        step();
        if_valid = 1'b0; #1;
        chk("t1_type", 32'(ins_type), 32'h13);
        chk("t1_rd", 32'(rd_addr), 32'd1);
        chk("t1_imm", imm, 32'd5);
        chk("t1_r1", 32'(r1_addr), 32'd0);
        step();

        // Bypass of x2 while decoding add x3,x2,x2, then regfile read
        fetch(32'h104, 32'h0021_01B3); #1; step();
        stl = 1'b1; wb_enable = 1'b1; wb_addr = 5'd2; wb_data = 32'hDEAD_BEEF; #1;
        chk("t2_byp1", r1_data, 32'hDEAD_BEEF);
        chk("t2_byp2", r2_data, 32'hDEAD_BEEF);
        step();
        wb_enable = 1'b0; #1;
        chk("t2_rf", r1_data, 32'hDEAD_BEEF);
        step();
        stl = 1'b0;

        // Write to x0 is ignored, also in the bypass path
        wb_enable = 1'b1; wb_addr = 5'd0; wb_data = 32'd7;
        fetch(32'h108, 32'h0000_0233); #1; step();
        if_valid = 1'b0; #1;
        chk("t3_x0", r1_data, 32'd0);
        step();
        wb_enable = 1'b0; #1; step();

        // Load-use hazard on add x6,x5,x1
        fetch(32'h10C, 32'h0012_8333); #1; step();
        ex_ins_type = 7'b0000011; ex_rd_addr = 5'd5;
        fetch(32'h200, 32'h0050_0093); #1;
        chk("t4_lus", 32'(load_use_stall), 32'd1);
        chk("t4_bub", 32'(rd_addr), 32'd0);
        step();
        #1;
        chk("t4_hold", pc, 32'h10C);
        step();
        ex_rd_addr = 5'd0; #1;
        chk("t4_rel", 32'(rd_addr), 32'd6);
        chk("t4_r1", 32'(r1_addr), 32'd5);
        step();

        // Reset during a hazard releases the stall
        fetch(32'h300, 32'h0012_8333); #1; step();
        ex_rd_addr = 5'd5; rst = 1'b1; if_valid = 1'b0; #1;
        chk("rh_lus1", 32'(load_use_stall), 32'd1);
        step();
        rst = 1'b0; #1;
        chk("rh_lus0", 32'(load_use_stall), 32'd0);
        step();
        ex_ins_type = '0;

        // beq with negative offset, then clear and stall together
        fetch(32'h400, 32'hFE00_0CE3); #1; step();
        clr = 1'b1; stl = 1'b1; if_valid = 1'b0; #1;
        chk("t5_imm", imm, 32'hFFFF_FFF8);
        chk("t5_rd", 32'(rd_addr), 32'd0);
        step();
        clr = 1'b0; stl = 1'b0; #1;
        chk("t5_type", 32'(ins_type), 32'h13);
        chk("t5_pc", pc, 32'd0);
        step();

        // rdy_in low freezes latch and regfile
        fetch(32'h500, 32'h0050_0093); #1; step();
        rdy = 1'b0; wb_enable = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234_5678;
        fetch(32'h600, 32'h0003_8433);
        for (int i = 0; i < 3; i++) begin
            #1; chk("t6_pc", pc, 32'h500); step();
        end
        rdy = 1'b1; wb_enable = 1'b0; #1; step();
        if_valid = 1'b0; #1;
        chk("t6_r1a", 32'(r1_addr), 32'd7);
        chk("t6_x7", r1_data, 32'd0);
        step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            clr = ($urandom_range(0, 9) == 0);
            stl = ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 7) != 0);
            if_valid = ($urandom_range(0, 3) != 0);
            if_pc = $urandom;
            rnd = $urandom;
            rnd[6:0]   = opcs[$urandom_range(0, 9)];
            rnd[19:15] = 5'($urandom_range(0, 7));
            rnd[24:20] = 5'($urandom_range(0, 7));
            if_inst = rnd;
            wb_enable = $urandom_range(0, 1) == 1;
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            ex_ins_type = ($urandom_range(0, 1) == 1) ? 7'b0000011 : opcs[$urandom_range(0, 9)];
            ex_rd_addr = 5'($urandom_range(0, 7));
            #1;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
